// File: rtl/imm_rot_encoder.sv
// Iterative search for the {rot, imm8} data-processing immediate encoding of a 32-bit constant.
// Optional IMM_ROT_ENCODER_DUAL_EN tests two rotations per cycle.
module imm_rot_encoder #(
   parameter bit HOLD_RESULT = 1'b1,
   parameter int MAX_ROT     = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] value,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic        found,
   output logic [11:0] imm12
);

   // state  | meaning
   // IDLE   | waiting for start, ready=1
   // SEARCH | testing rotation(s) r against the latched value
   // DONE   | one-cycle done pulse, result valid
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [4:0] MAX_ROT_W = 5'(MAX_ROT);

   state_t      state_q, state_d;
   logic [3:0]  r_q, r_d;
   logic [31:0] value_q, value_d;
   logic        found_q, found_d;
   logic [11:0] imm12_q, imm12_d;

   function automatic logic [31:0] rol32(input logic [31:0] v, input logic [5:0] amt);
      logic [63:0] w;
      w = {v, v} << amt;
      return w[63:32];
   endfunction

   logic [4:0]  r_ext;
   logic [31:0] t_lo;
   logic        hit_lo;
   logic        last_lo;

   assign r_ext   = {1'b0, r_q};
   assign t_lo    = rol32(value_q, {r_ext, 1'b0});
   assign hit_lo  = (t_lo[31:8] == 24'd0);
   assign last_lo = (r_ext >= MAX_ROT_W);

`ifdef IMM_ROT_ENCODER_DUAL_EN
   logic [4:0]  r_hi;
   logic [31:0] t_hi;
   logic        hit_hi;
   logic        last_pair;

   // The upper rotation only counts when it is still within the tested range.
   assign r_hi      = r_ext + 5'd1;
   assign t_hi      = rol32(value_q, {r_hi, 1'b0});
   assign hit_hi    = (t_hi[31:8] == 24'd0) && (r_hi <= MAX_ROT_W);
   assign last_pair = (r_hi >= MAX_ROT_W);
`endif

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      value_d = value_q;
      found_d = found_q;
      imm12_d = imm12_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               value_d = value;
               r_d     = 4'd0;
               found_d = 1'b0;
               imm12_d = 12'h000;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
`ifdef IMM_ROT_ENCODER_DUAL_EN
            if (hit_lo) begin
               found_d = 1'b1;
               imm12_d = {r_q, t_lo[7:0]};
               state_d = DONE;
            end else if (hit_hi) begin
               found_d = 1'b1;
               imm12_d = {r_hi[3:0], t_hi[7:0]};
               state_d = DONE;
            end else if (last_pair || last_lo) begin
               found_d = 1'b0;
               imm12_d = 12'h000;
               state_d = DONE;
            end else begin
               r_d = r_q + 4'd2;
            end
`else
            if (hit_lo) begin
               found_d = 1'b1;
               imm12_d = {r_q, t_lo[7:0]};
               state_d = DONE;
            end else if (last_lo) begin
               found_d = 1'b0;
               imm12_d = 12'h000;
               state_d = DONE;
            end else begin
               r_d = r_q + 4'd1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
            if (!HOLD_RESULT) begin
               found_d = 1'b0;
               imm12_d = 12'h000;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= 4'd0;
         value_q <= 32'd0;
         found_q <= 1'b0;
         imm12_q <= 12'h000;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         value_q <= value_d;
         found_q <= found_d;
         imm12_q <= imm12_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign busy  = (state_q == SEARCH);
   assign done  = (state_q == DONE);
   assign found = found_q;
   assign imm12 = imm12_q;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Randomized self-checking bench for imm_rot_encoder against a rotation-search reference model.
module tb_imm_rot_encoder;
   localparam int MAX_ROT = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] value;
   logic        ready, busy, done, found;
   logic [11:0] imm12;

   int errors = 0;
   int checks = 0;

   imm_rot_encoder #(.HOLD_RESULT(1'b1), .MAX_ROT(MAX_ROT)) dut (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .ready(ready), .busy(busy), .done(done), .found(found), .imm12(imm12)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ror32(input logic [31:0] v, input int s);
      logic [63:0] w;
      w = {v, 32'd0} >> s;
      return w[63:32] | w[31:0];
   endfunction

   // Smallest rotation whose right-rotation of some byte reproduces v.
   function automatic void model(input logic [31:0] v, output bit f, output logic [11:0] imm, output int rot);
      f = 0; imm = 12'h000; rot = 0;
      for (int k = 0; k <= MAX_ROT; k++) begin
         for (int b = 0; b < 256; b++) begin
            if (!f && ror32(32'(b), 2 * k) == v) begin
               f = 1; rot = k; imm = {4'(k), 8'(b)};
            end
         end
      end
   endfunction

   function automatic int exp_latency(input bit f, input int rot);
      int r;
      r = f ? rot : MAX_ROT;
`ifdef IMM_ROT_ENCODER_DUAL_EN
      return r / 2 + 2;
`else
      return r + 2;
`endif
   endfunction

   task automatic run(input logic [31:0] v, input bit hold_start, input bit wiggle);
      bit          e_f, seen;
      logic [11:0] e_imm;
      int          e_rot, cyc;
      model(v, e_f, e_imm, e_rot);
      @(negedge clk);
      chk("ready_idle", ready, 1);
      value = v; start = 1'b1;
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      seen = 0;
      while (!seen && cyc < 40) begin
         if (done) seen = 1;
         else begin
            chk("busy_search", busy, 1);
            if (wiggle) value = $urandom;
            @(posedge clk); cyc++;
            @(negedge clk);
         end
      end
      start = 1'b0;
      chk("done_seen", 32'(seen), 1);
      chk("latency", cyc, exp_latency(e_f, e_rot));
      chk("found", found, e_f);
      chk("imm12", imm12, e_imm);
      chk("ready_in_done", ready, 0);
      if (found) chk("ror_property", ror32({24'd0, imm12[7:0]}, 2 * imm12[11:8]), v);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("ready_after", ready, 1);
      chk("imm12_held", imm12, e_imm);
   endtask

   initial begin
      bit          ok;
      logic [31:0] rv;
      rst = 1'b1; start = 1'b0; value = 32'd0;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_found", found, 0);
      chk("rst_imm12", imm12, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run(32'h0000_00FF, 0, 0);
      run(32'hC000_0003, 0, 0);
      run(32'hFF00_0000, 0, 0);
      run(32'h0000_0104, 0, 0);
      run(32'h0000_0101, 0, 0);
      run(32'h0000_3FC0, 1, 1);
      run(32'h0000_0101, 1, 1);

      // reset while the search is at rotation 7
      @(negedge clk);
      value = 32'h0000_0101; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_ready", ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_found", found, 0);
      chk("midrst_imm12", imm12, 0);
      @(negedge clk); rst = 1'b0;
      ok = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || busy) ok = 0;
      end
      chk("no_done_after_rst", 32'(ok), 1);
      run(32'h0000_0000, 0, 0);

      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) rv = $urandom;
         else rv = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
         run(rv, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
